// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder with req/ready handshake and one-cycle response pulse
module dmem_responder #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 5,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MEM_req,
  input  logic                 MEM_str,
  input  logic [ADDR_SIZE-1:0] MEM_addr,
  input  logic [XLEN-1:0]      MEM_wdata,
  output logic                 MEM_ready,
  output logic                 MEM_rvalid,
  output logic [XLEN-1:0]      MEM_rdata,
  output logic                 MEM_busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  state_t r_state, w_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic r_str;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [XLEN-1:0] r_wdata, r_rdata;
  logic [XLEN-1:0] r_mem [2**ADDR_SIZE];
  logic w_accept, w_commit, w_str;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [XLEN-1:0] w_wdata;
  assign MEM_ready  = r_state != WAIT;
  assign w_accept   = MEM_req & MEM_ready;
  assign MEM_busy   = (r_state == WAIT) | w_accept;
  assign MEM_rvalid = r_state == RESP;
  assign MEM_rdata  = r_rdata;
  // with LATENCY=1 the commit edge is the accept edge, so the live request fields are used
  assign w_str   = (r_state == WAIT) ? r_str   : MEM_str;
  assign w_addr  = (r_state == WAIT) ? r_addr  : MEM_addr;
  assign w_wdata = (r_state == WAIT) ? r_wdata : MEM_wdata;
  assign w_commit = w_next == RESP;
  always_comb begin
    w_next     = (r_state == WAIT) ? ((r_cnt == 4'd1) ? RESP : WAIT)
               : (w_accept ? ((LATENCY == 1) ? RESP : WAIT) : IDLE);
    w_cnt_next = (r_state == WAIT) ? r_cnt - 4'd1 : (w_accept ? LAT_M1 : r_cnt);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_str   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      for (int i = 0; i < 2**ADDR_SIZE; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_str   <= MEM_str;
        r_addr  <= MEM_addr;
        r_wdata <= MEM_wdata;
      end
      if (w_commit) begin
        if (w_str) r_mem[w_addr] <= w_wdata;
        r_rdata <= w_str ? '0 : r_mem[w_addr];
      end
    end
  end
endmodule
